// File: rtl/decode_sequencer.sv
// Multi-cycle decode/ALU sequencer feeding a registered-read register file; `DECODE_SEQ_R0_ZERO_EN hardwires r0 to zero.
// Latency: handshake -> READ -> EXEC -> WB, write commits 3 edges after accept (rd=0 skips WB when r0 is hardwired).
// Backpressure: instr_ready is high only in IDLE; NOP/illegal retire in one cycle, HALT holds ready low until reset.
module decode_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  rs_addr,
    output logic [2:0]  rt_addr,
    output logic [2:0]  rd_addr,
    output logic        rf_write,
    output logic [15:0] rf_wdata,
    input  logic [15:0] rs_data,
    input  logic [15:0] rt_data,
    output logic        zero,
    output logic        carry,
    output logic        illegal,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t      r_state;
    logic [3:0]  r_op;
    logic [15:0] r_imm;

    logic        w_hs;
    logic [3:0]  w_op;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [16:0] w_ext;
    logic [15:0] w_result;
    logic        w_cy_upd;

    assign w_hs = instr_valid && instr_ready;
    assign w_op = instr[15:12];

    always_comb begin
        w_a = rs_data;
        w_b = rt_data;
`ifdef DECODE_SEQ_R0_ZERO_EN
        if (rs_addr == 3'd0) w_a = 16'd0;
        if (rt_addr == 3'd0) w_b = 16'd0;
`endif
    end

    // 17-bit sum/difference so bit 16 is carry for add and borrow for subtract
    always_comb begin
        w_ext    = 17'd0;
        w_result = 16'd0;
        w_cy_upd = 1'b0;
        case (r_op)
            4'd1: begin
                w_ext    = {1'b0, w_a} + {1'b0, w_b};
                w_result = w_ext[15:0];
                w_cy_upd = 1'b1;
            end
            4'd2: begin
                w_ext    = {1'b0, w_a} - {1'b0, w_b};
                w_result = w_ext[15:0];
                w_cy_upd = 1'b1;
            end
            4'd3: w_result = w_a & w_b;
            4'd4: w_result = w_a | w_b;
            4'd5: w_result = w_a ^ w_b;
            4'd6: w_result = w_a << w_b[3:0];
            4'd7: w_result = w_a >> w_b[3:0];
            4'd8: begin
                w_ext    = {1'b0, w_a} + {1'b0, r_imm};
                w_result = w_ext[15:0];
                w_cy_upd = 1'b1;
            end
            4'd9: w_result = r_imm;
            default: w_result = 16'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= 4'd0;
            r_imm       <= 16'd0;
            instr_ready <= 1'b1;
            rs_addr     <= 3'd0;
            rt_addr     <= 3'd0;
            rd_addr     <= 3'd0;
            rf_write    <= 1'b0;
            rf_wdata    <= 16'd0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            illegal     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        if (w_op == 4'd15) begin
                            r_state     <= S_HALT;
                            instr_ready <= 1'b0;
                            halted      <= 1'b1;
                        end else if (w_op >= 4'd10) begin
                            illegal <= 1'b1;
                        end else if (w_op != 4'd0) begin
                            r_op        <= w_op;
                            rd_addr     <= instr[11:9];
                            rs_addr     <= instr[8:6];
                            rt_addr     <= instr[5:3];
                            r_imm       <= {{10{instr[5]}}, instr[5:0]};
                            instr_ready <= 1'b0;
                            r_state     <= S_READ;
                        end
                    end
                end
                S_READ: r_state <= S_EXEC;
                S_EXEC: begin
                    zero <= (w_result == 16'd0);
                    if (w_cy_upd) carry <= w_ext[16];
`ifdef DECODE_SEQ_R0_ZERO_EN
                    if (rd_addr == 3'd0) begin
                        instr_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        rf_wdata <= w_result;
                        rf_write <= 1'b1;
                        r_state  <= S_WB;
                    end
`else
                    rf_wdata <= w_result;
                    rf_write <= 1'b1;
                    r_state  <= S_WB;
`endif
                end
                S_WB: begin
                    rf_write    <= 1'b0;
                    instr_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_HALT: begin
                    instr_ready <= 1'b0;
                    halted      <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer with a behavioural registered-read register file.
module tb_decode_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] instr = 16'd0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  rs_addr, rt_addr, rd_addr;
    logic        rf_write;
    logic [15:0] rf_wdata;
    logic [15:0] rs_data = 16'd0;
    logic [15:0] rt_data = 16'd0;
    logic        zero, carry, illegal, halted;

    logic [15:0] regs [0:7];
    logic        seed_req = 1'b0;
    logic [2:0]  seed_addr = 3'd0;
    logic [15:0] seed_dat = 16'd0;
    logic        force_rs = 1'b0;
    int          wr_count = 0;
    logic [15:0] last_wr_dat = 16'd0;
    int          total = 0;
    int          bad = 0;

    wire [30:0] w_outs = {instr_ready, rf_write, rs_addr, rt_addr, rd_addr,
                          rf_wdata, zero, carry, illegal, halted};
    localparam logic [30:0] RST_OUTS = {1'b1, 30'd0};

    decode_sequencer dut (
        .clock(clock), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .rf_write(rf_write), .rf_wdata(rf_wdata), .rs_data(rs_data), .rt_data(rt_data),
        .zero(zero), .carry(carry), .illegal(illegal), .halted(halted)
    );

    always #5 clock = ~clock;

    // Register file model: registered reads, reads suppressed while writing
    always @(posedge clock) begin
        if (seed_req) regs[seed_addr] <= seed_dat;
        else if (rf_write) regs[rd_addr] <= rf_wdata;
        if (rf_write) begin
            wr_count    <= wr_count + 1;
            last_wr_dat <= rf_wdata;
        end else begin
            rs_data <= force_rs ? 16'h1234 : regs[rs_addr];
            rt_data <= regs[rt_addr];
        end
    end

    task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
        @(negedge clock);
        seed_addr = a;
        seed_dat  = d;
        seed_req  = 1'b1;
        @(negedge clock);
        seed_req  = 1'b0;
    endtask

    task automatic run_alu(input logic [15:0] ins, input logic [2:0] erd, input logic [15:0] edat,
                           input logic ez, input logic ec, input string name);
        int w0;
        @(negedge clock);
        w0 = wr_count;
        instr = ins;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        total++;
        if (instr_ready !== 1'b0) begin bad++; $display("FAIL %s_read_ready: got %b want 0", name, instr_ready); end
        @(negedge clock);
        total++;
        if (rf_write !== 1'b0) begin bad++; $display("FAIL %s_exec_wr: got %b want 0", name, rf_write); end
        @(negedge clock);
        total++;
        if ({rf_write, rd_addr, rf_wdata} !== {1'b1, erd, edat}) begin
            bad++;
            $display("FAIL %s_wb: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h",
                     name, rf_write, rd_addr, rf_wdata, erd, edat);
        end
        @(negedge clock);
        total++;
        if ({instr_ready, rf_write, zero, carry} !== {1'b1, 1'b0, ez, ec} || wr_count !== w0 + 1) begin
            bad++;
            $display("FAIL %s_after: got rdy=%b we=%b z=%b c=%b writes=%0d want rdy=1 we=0 z=%b c=%b writes=%0d",
                     name, instr_ready, rf_write, zero, carry, wr_count - w0, ez, ec, 1);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        total++;
        if (w_outs !== RST_OUTS) begin bad++; $display("FAIL reset_outs: got %h want %h", w_outs, RST_OUTS); end
        for (int i = 0; i < 8; i++) set_reg(i[2:0], 16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if (w_outs !== RST_OUTS) begin bad++; $display("FAIL reset_idle: got %h want %h", w_outs, RST_OUTS); end
    endtask

    task automatic test_arith;
        set_reg(3'd1, 16'h0005);
        set_reg(3'd2, 16'h0007);
        run_alu(16'h1650, 3'd3, 16'h000C, 1'b0, 1'b0, "add");
        set_reg(3'd1, 16'h0002);
        set_reg(3'd2, 16'h0003);
        run_alu(16'h2850, 3'd4, 16'hFFFF, 1'b0, 1'b1, "sub_borrow");
        set_reg(3'd1, 16'h0001);
        run_alu(16'h1B08, 3'd5, 16'h0000, 1'b1, 1'b1, "add_wrap");
        set_reg(3'd1, 16'h0010);
        run_alu(16'h827F, 3'd1, 16'h000F, 1'b0, 1'b1, "addi_neg");
        run_alu(16'h9A20, 3'd5, 16'hFFE0, 1'b0, 1'b1, "li_neg");
    endtask

    task automatic test_logic_shift;
        run_alu(16'h6458, 3'd2, 16'hF000, 1'b0, 1'b1, "sll");
        run_alu(16'h7C80, 3'd6, 16'hF000, 1'b0, 1'b1, "srl_zero_amt");
        run_alu(16'h3708, 3'd3, 16'h000F, 1'b0, 1'b1, "and");
        run_alu(16'h7C98, 3'd6, 16'h0001, 1'b0, 1'b1, "srl15");
        run_alu(16'h5F68, 3'd7, 16'h0000, 1'b1, 1'b1, "xor_self");
        run_alu(16'h4E88, 3'd7, 16'hF00F, 1'b0, 1'b1, "or");
    endtask

    task automatic test_back_to_back;
        logic [5:0] pat;
        int w0;
        @(negedge clock);
        w0 = wr_count;
        pat[0] = instr_ready;
        instr = 16'h1E48;
        instr_valid = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clock);
            pat[i] = instr_ready;
        end
        @(negedge clock);
        pat[4] = instr_ready;
        instr = 16'h0000;
        @(negedge clock);
        pat[5] = instr_ready;
        total++;
        if (illegal !== 1'b0) begin bad++; $display("FAIL b2b_illegal_early: got %b want 0", illegal); end
        instr = 16'hC000;
        @(negedge clock);
        instr_valid = 1'b0;
        total++;
        if (pat !== 6'b110001) begin bad++; $display("FAIL b2b_ready_pattern: got %b want 110001", pat); end
        total++;
        if (illegal !== 1'b1) begin bad++; $display("FAIL b2b_illegal: got %b want 1", illegal); end
        repeat (3) @(negedge clock);
        total++;
        if (wr_count !== w0 + 1 || last_wr_dat !== 16'h001E) begin
            bad++;
            $display("FAIL b2b_writes: got n=%0d data=%h want n=1 data=001e", wr_count - w0, last_wr_dat);
        end
    endtask

    task automatic test_halt;
        int w0;
        @(negedge clock);
        w0 = wr_count;
        instr = 16'hF000;
        instr_valid = 1'b1;
        @(negedge clock);
        instr = 16'h1650;
        total++;
        if ({halted, instr_ready} !== 2'b10) begin bad++; $display("FAIL halt_enter: got h=%b r=%b want h=1 r=0", halted, instr_ready); end
        repeat (6) @(negedge clock);
        total++;
        if ({halted, instr_ready} !== 2'b10 || wr_count !== w0) begin
            bad++;
            $display("FAIL halt_hold: got h=%b r=%b writes=%0d want h=1 r=0 writes=0", halted, instr_ready, wr_count - w0);
        end
        instr_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        total++;
        if (w_outs !== RST_OUTS) begin bad++; $display("FAIL halt_reset: got %h want %h", w_outs, RST_OUTS); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if (w_outs !== RST_OUTS) begin bad++; $display("FAIL halt_post_reset: got %h want %h", w_outs, RST_OUTS); end
    endtask

    task automatic test_reset_exec;
        int w0;
        set_reg(3'd1, 16'h0005);
        set_reg(3'd2, 16'h0007);
        @(negedge clock);
        w0 = wr_count;
        instr = 16'h1650;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        total++;
        if (w_outs !== RST_OUTS) begin bad++; $display("FAIL exec_reset_outs: got %h want %h", w_outs, RST_OUTS); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        total++;
        if (wr_count !== w0 || instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL exec_reset_nowrite: got writes=%0d rdy=%b want writes=0 rdy=1", wr_count - w0, instr_ready);
        end
    endtask

`ifdef DECODE_SEQ_R0_ZERO_EN
    task automatic test_r0_zero;
        int w0;
        set_reg(3'd1, 16'h0005);
        set_reg(3'd2, 16'h0009);
        @(negedge clock);
        w0 = wr_count;
        instr = 16'h1050;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++;
        if ({instr_ready, rf_write, zero} !== 3'b100) begin
            bad++;
            $display("FAIL r0_skip_wb: got rdy=%b we=%b z=%b want rdy=1 we=0 z=0", instr_ready, rf_write, zero);
        end
        repeat (2) @(negedge clock);
        total++;
        if (wr_count !== w0) begin bad++; $display("FAIL r0_nowrite: got writes=%0d want 0", wr_count - w0); end
        force_rs = 1'b1;
        run_alu(16'h1C10, 3'd6, 16'h0009, 1'b0, 1'b0, "r0_operand");
        force_rs = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_arith;
        test_logic_shift;
        test_back_to_back;
        test_halt;
        test_reset_exec;
`ifdef DECODE_SEQ_R0_ZERO_EN
        test_r0_zero;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
